// File: rtl/readout_tx_pulse_shaper_google.sv
// Readout pulse shaper: plays ramp-up / hold / ramp-down from an envelope RAM.
// Define READOUT_TX_IQ_WEIGHT_EN to add a registered, saturating I/Q weighting stage.
module readout_tx_pulse_shaper_google #(
  parameter int DATA_WIDTH     = 8,
  parameter int ENV_ADDR_WIDTH = 6,
  parameter int LEN_WIDTH      = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      env_wr_en,
  input  logic [ENV_ADDR_WIDTH-1:0] env_wr_addr,
  input  logic [DATA_WIDTH-1:0]     env_wr_data,
  input  logic                      reg_wr_en,
  input  logic [1:0]                reg_wr_addr,
  input  logic [LEN_WIDTH-1:0]      reg_wr_data,
  input  logic                      meas_start,
  output logic [DATA_WIDTH-1:0]     i_out,
  output logic [DATA_WIDTH-1:0]     q_out,
  output logic                      sample_valid,
  output logic                      rx_start,
  output logic                      busy,
  output logic                      tx_done
);

  localparam int DEPTH = 1 << ENV_ADDR_WIDTH;
  localparam int RW    = ENV_ADDR_WIDTH + 1;
  localparam logic [RW-1:0] R_MAX = RW'(DEPTH);

  typedef enum logic [1:0] {IDLE, RAMP_UP, HOLD, RAMP_DOWN} state_t;
  state_t state, state_n;

  logic [DATA_WIDTH-1:0]     env_mem [DEPTH];
  logic [RW-1:0]             ramp_len, r_sh, r_sat, r_cur;
  logic [LEN_WIDTH-1:0]      hold_len, h_sh, h_cur, r_ext, cnt, cnt_n, down_idx;
  logic [ENV_ADDR_WIDTH-1:0] rd_addr, last_addr;
  logic [DATA_WIDTH-1:0]     rd_data;
  logic                      accept, emit, hold_zero, rx_n, done_n;

  // Stage-1 registered sample stream
  logic [DATA_WIDTH-1:0]     s1_samp;
  logic                      s1_valid, s1_rx, s1_done;

  // Asynchronous read feeding a register: a same-edge write yields the old word.
  always_ff @(posedge clk) begin
    if (env_wr_en) env_mem[env_wr_addr] <= env_wr_data;
  end
  assign rd_data = env_mem[rd_addr];

  assign r_sat     = (ramp_len > R_MAX) ? R_MAX : ramp_len;
  assign accept    = (state == IDLE) && meas_start;
  // In IDLE the shadows are being loaded this edge, so decode from the live registers.
  assign r_cur     = (state == IDLE) ? r_sat : r_sh;
  assign h_cur     = (state == IDLE) ? hold_len : h_sh;
  assign r_ext     = LEN_WIDTH'(r_cur);
  assign last_addr = ENV_ADDR_WIDTH'(r_cur - RW'(1));
  assign down_idx  = r_ext - LEN_WIDTH'(1) - cnt;

  // cnt holds the number of samples already emitted in the current phase.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    emit      = 1'b0;
    hold_zero = 1'b0;
    rx_n      = 1'b0;
    done_n    = 1'b0;
    rd_addr   = last_addr;
    unique case (state)
      IDLE: begin
        if (meas_start) begin
          if (r_ext != '0) begin
            state_n = RAMP_UP;
            cnt_n   = LEN_WIDTH'(1);
            emit    = 1'b1;
            rx_n    = 1'b1;
            rd_addr = '0;
          end else if (h_cur != '0) begin
            state_n   = HOLD;
            cnt_n     = LEN_WIDTH'(1);
            emit      = 1'b1;
            rx_n      = 1'b1;
            hold_zero = 1'b1;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      RAMP_UP: begin
        emit = 1'b1;
        if (cnt < r_ext) begin
          cnt_n   = cnt + LEN_WIDTH'(1);
          rd_addr = cnt[ENV_ADDR_WIDTH-1:0];
        end else begin
          cnt_n   = LEN_WIDTH'(1);
          state_n = (h_cur != '0) ? HOLD : RAMP_DOWN;
        end
      end
      HOLD: begin
        if (cnt < h_cur) begin
          cnt_n     = cnt + LEN_WIDTH'(1);
          emit      = 1'b1;
          hold_zero = (r_ext == '0);
        end else if (r_ext != '0) begin
          state_n = RAMP_DOWN;
          cnt_n   = LEN_WIDTH'(1);
          emit    = 1'b1;
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end
      end
      RAMP_DOWN: begin
        if (cnt < r_ext) begin
          cnt_n   = cnt + LEN_WIDTH'(1);
          emit    = 1'b1;
          rd_addr = down_idx[ENV_ADDR_WIDTH-1:0];
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ramp_len <= '0;
      hold_len <= '0;
      r_sh     <= '0;
      h_sh     <= '0;
      s1_samp  <= '0;
      s1_valid <= 1'b0;
      s1_rx    <= 1'b0;
      s1_done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        r_sh <= r_sat;
        h_sh <= hold_len;
      end
      if (reg_wr_en) begin
        case (reg_wr_addr)
          2'd0:    ramp_len <= reg_wr_data[ENV_ADDR_WIDTH:0];
          2'd1:    hold_len <= reg_wr_data;
          default: ;
        endcase
      end
      s1_samp  <= (emit && !hold_zero) ? rd_data : '0;
      s1_valid <= emit;
      s1_rx    <= rx_n;
      s1_done  <= done_n;
    end
  end

`ifdef READOUT_TX_IQ_WEIGHT_EN
  logic [DATA_WIDTH-1:0] i_weight, q_weight, iw_sh, qw_sh;

  // Q1.x product; only (-1)*(-1) can overflow the kept field.
  function automatic logic [DATA_WIDTH-1:0] sat_mul(input logic signed [DATA_WIDTH-1:0] a,
                                                    input logic signed [DATA_WIDTH-1:0] b);
    logic signed [2*DATA_WIDTH-1:0] p;
    p = a * b;
    if (p[2*DATA_WIDTH-1] != p[2*DATA_WIDTH-2])
      sat_mul = p[2*DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      sat_mul = p[2*DATA_WIDTH-2:DATA_WIDTH-1];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      i_weight     <= '0;
      q_weight     <= '0;
      iw_sh        <= '0;
      qw_sh        <= '0;
      i_out        <= '0;
      q_out        <= '0;
      sample_valid <= 1'b0;
      rx_start     <= 1'b0;
      busy         <= 1'b0;
      tx_done      <= 1'b0;
    end else begin
      if (reg_wr_en && reg_wr_addr == 2'd2) i_weight <= reg_wr_data[DATA_WIDTH-1:0];
      if (reg_wr_en && reg_wr_addr == 2'd3) q_weight <= reg_wr_data[DATA_WIDTH-1:0];
      if (accept) begin
        iw_sh <= i_weight;
        qw_sh <= q_weight;
      end
      i_out        <= s1_valid ? sat_mul(s1_samp, iw_sh) : '0;
      q_out        <= s1_valid ? sat_mul(s1_samp, qw_sh) : '0;
      sample_valid <= s1_valid;
      rx_start     <= s1_rx;
      busy         <= s1_valid;
      tx_done      <= s1_done;
    end
  end
`else
  assign i_out        = s1_samp;
  assign q_out        = '0;
  assign sample_valid = s1_valid;
  assign rx_start     = s1_rx;
  assign busy         = s1_valid;
  assign tx_done      = s1_done;
`endif

endmodule

// File: tb/tb_readout_tx_pulse_shaper_google.sv
// Bench for readout_tx_pulse_shaper_google: vector table, hand sequences and a random
// run against a cycle-indexed expectation map built from the pulse rules.
module tb_readout_tx_pulse_shaper_google;
  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int LW    = 10;
  localparam int DEPTH = 1 << AW;
`ifdef READOUT_TX_IQ_WEIGHT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          env_wr_en = 1'b0;
  logic [AW-1:0] env_wr_addr = '0;
  logic [DW-1:0] env_wr_data = '0;
  logic          reg_wr_en = 1'b0;
  logic [1:0]    reg_wr_addr = '0;
  logic [LW-1:0] reg_wr_data = '0;
  logic          meas_start = 1'b0;
  logic [DW-1:0] i_out, q_out;
  logic          sample_valid, rx_start, busy, tx_done;

  readout_tx_pulse_shaper_google #(.DATA_WIDTH(DW), .ENV_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .env_wr_en(env_wr_en), .env_wr_addr(env_wr_addr), .env_wr_data(env_wr_data),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .meas_start(meas_start),
    .i_out(i_out), .q_out(q_out), .sample_valid(sample_valid),
    .rx_start(rx_start), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [DW-1:0] i, input logic [DW-1:0] q,
                                       input logic v, input logic rx, input logic b, input logic d);
    return {12'b0, i, q, v, rx, b, d};
  endfunction

`ifdef READOUT_TX_IQ_WEIGHT_EN
  function automatic logic [DW-1:0] wmul(input logic [DW-1:0] s, input int w);
    int p;
    p = (int'($signed(s)) * w) >>> (DW - 1);
    if (p > (1 << (DW - 1)) - 1) p = (1 << (DW - 1)) - 1;
    if (p < -(1 << (DW - 1))) p = -(1 << (DW - 1));
    return DW'(p);
  endfunction
`endif

  // Reference model: every cycle c in [T, T+N) reads one envelope word, visible at c+1+LAT.
  logic [DW-1:0] m_env [DEPTH];
  logic [31:0]   exp_q [int];
  int  cyc = 0, busy_end = -1;
  int  m_ramp = 0, m_hold = 0, m_iw = 0, m_qw = 0;
  int  p_t = 0, p_n = 0, p_r = 0, p_h = 0, p_iw = 0, p_qw = 0, j = 0;
  bit  p_act = 0;
  bit  chk_en = 0;
  logic [DW-1:0] s, ei, eq;

  initial begin : model
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        chk_en = 1'b1;
        m_ramp = 0; m_hold = 0; m_iw = 0; m_qw = 0;
        p_act = 0;
        busy_end = cyc;
        foreach (m_env[k]) m_env[k] = 'x;
      end else begin
        if (meas_start && cyc > busy_end) begin
          p_t = cyc;
          p_r = (m_ramp > DEPTH) ? DEPTH : m_ramp;
          p_h = m_hold;
          p_iw = m_iw;
          p_qw = m_qw;
          p_n = 2 * p_r + p_h;
          busy_end = cyc + p_n;
          p_act = 1;
        end
        if (p_act && cyc < p_t + p_n) begin
          j = cyc - p_t;
          if (j < p_r) s = m_env[j];
          else if (j < p_r + p_h) begin
            if (p_r > 0) s = m_env[p_r - 1];
            else s = '0;
          end else s = m_env[p_r - 1 - (j - p_r - p_h)];
`ifdef READOUT_TX_IQ_WEIGHT_EN
          ei = wmul(s, p_iw);
          eq = wmul(s, p_qw);
`else
          ei = s;
          eq = '0;
`endif
          exp_q[cyc + 1 + LAT] = pack(ei, eq, 1'b1, (j == 0), 1'b1, 1'b0);
        end else if (p_act && cyc == p_t + p_n) begin
          exp_q[cyc + 1 + LAT] = pack('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
          p_act = 0;
        end
        if (reg_wr_en) begin
          case (reg_wr_addr)
            2'd0: m_ramp = int'(reg_wr_data[AW:0]);
            2'd1: m_hold = int'(reg_wr_data);
            2'd2: m_iw   = int'($signed(reg_wr_data[DW-1:0]));
            default: m_qw = int'($signed(reg_wr_data[DW-1:0]));
          endcase
        end
      end
      if (env_wr_en) m_env[env_wr_addr] = env_wr_data;
      cyc++;
    end
  end

  logic [31:0] sb_exp;
  initial begin : scoreboard
    forever begin
      @(negedge clk);
      if (chk_en) begin
        sb_exp = '0;
        if (exp_q.exists(cyc)) begin
          sb_exp = exp_q[cyc];
          exp_q.delete(cyc);
        end
        check($sformatf("scoreboard@%0d", cyc),
              pack(i_out, q_out, sample_valid, rx_start, busy, tx_done), sb_exp);
      end
    end
  end

  task automatic env_wr(input int a, input logic [DW-1:0] d);
    env_wr_en = 1'b1; env_wr_addr = AW'(a); env_wr_data = d;
    @(negedge clk);
    env_wr_en = 1'b0;
  endtask

  task automatic reg_wr(input int a, input int d);
    reg_wr_en = 1'b1; reg_wr_addr = 2'(a); reg_wr_data = LW'(d);
    @(negedge clk);
    reg_wr_en = 1'b0;
  endtask

  task automatic load_env();
    for (int k = 0; k < DEPTH; k++) env_wr(k, (k < 4) ? DW'(10 * k) : DW'($urandom));
  endtask

  task automatic pulse_start();
    meas_start = 1'b1;
    @(negedge clk);
    meas_start = 1'b0;
  endtask

  // Starts a pulse and counts valid/busy cycles until tx_done (offset from T), bounded.
  task automatic play(input int mid_hold, output int nval, output int nbusy, output int done_off);
    pulse_start();
    nval = 0; nbusy = 0; done_off = 0;
    for (int off = 1; off <= 400; off++) begin
      if (mid_hold >= 0 && off == 2) begin
        reg_wr_en = 1'b1; reg_wr_addr = 2'd1; reg_wr_data = LW'(mid_hold);
      end else reg_wr_en = 1'b0;
      if (sample_valid) nval++;
      if (busy) nbusy++;
      if (tx_done) begin
        done_off = off;
        break;
      end
      @(negedge clk);
    end
    reg_wr_en = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!tx_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(tx_done), 32'd1);
  endtask

  typedef struct {
    int r;
    int h;
    int exp_valid;
    int exp_done;
  } vec_t;

  vec_t tbl [8];
  logic [DW-1:0] ref43 [10];
  int nv, nb, d, ndone;

  initial begin : stim
    tbl[0] = '{4,   2, 10,  11};
    tbl[1] = '{0,   0, 0,   1};
    tbl[2] = '{0,   3, 3,   4};
    tbl[3] = '{1,   0, 2,   3};
    tbl[4] = '{100, 1, 129, 130};
    tbl[5] = '{64,  0, 128, 129};
    tbl[6] = '{2,   5, 9,   10};
    tbl[7] = '{127, 0, 128, 129};
    ref43 = '{8'd0, 8'd10, 8'd20, 8'd30, 8'd30, 8'd30, 8'd30, 8'd20, 8'd10, 8'd0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_outputs", pack(i_out, q_out, sample_valid, rx_start, busy, tx_done), '0);
    load_env();

`ifdef READOUT_TX_IQ_WEIGHT_EN
    reg_wr(2, 'h080);
    reg_wr(3, 'h040);
    env_wr(0, 8'h80);
    reg_wr(0, 1);
    reg_wr(1, 0);
    pulse_start();
    @(negedge clk);
    check("weight_sat_iq", 32'({i_out, q_out}), 32'({8'h7f, 8'hc0}));
    wait_done("weight_done");
    env_wr(0, 8'h00);
    reg_wr(2, 'h040);
`else
    reg_wr(0, 4);
    reg_wr(1, 2);
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      check($sformatf("ref_pulse_s%0d", k), 32'({sample_valid, rx_start, busy, i_out}),
            32'({1'b1, (k == 0), 1'b1, ref43[k]}));
      @(negedge clk);
    end
    check("ref_pulse_done", 32'({tx_done, busy, sample_valid}), 32'b100);
`endif

    foreach (tbl[v]) begin
      reg_wr(0, tbl[v].r);
      reg_wr(1, tbl[v].h);
      play(-1, nv, nb, d);
      check($sformatf("tbl%0d_valid", v), 32'(nv), 32'(tbl[v].exp_valid));
      check($sformatf("tbl%0d_busy", v), 32'(nb), 32'(tbl[v].exp_valid));
      check($sformatf("tbl%0d_done", v), 32'(d), 32'(tbl[v].exp_done + LAT));
    end

    // Mid-pulse start ignored; start in the tx_done cycle begins the next pulse.
    reg_wr(0, 2);
    reg_wr(1, 1);
    pulse_start();
    @(negedge clk);
    pulse_start();
    nv = 3;
    while (!tx_done && nv < 50) begin
      @(negedge clk);
      nv++;
    end
    check("repeat_ignored_done", 32'(nv), 32'(6 + LAT));
    pulse_start();
    repeat (LAT) @(negedge clk);
    check("restart_first", 32'({sample_valid, rx_start}), 32'b11);
    wait_done("restart_done");

    // hold_len written mid-pulse only affects the following pulse.
    reg_wr(0, 1);
    reg_wr(1, 2);
    play(7, nv, nb, d);
    check("midwr_cur_valid", 32'(nv), 32'd4);
    play(-1, nv, nb, d);
    check("midwr_next_valid", 32'(nv), 32'd9);

    // Reset during sample 3 aborts the pulse and clears lengths.
    reg_wr(0, 4);
    reg_wr(1, 2);
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_abort_outputs", pack(i_out, q_out, sample_valid, rx_start, busy, tx_done), '0);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (tx_done) ndone++;
      @(negedge clk);
    end
    check("rst_no_done", 32'(ndone), 32'd0);
    play(-1, nv, nb, d);
    check("rst_len_cleared_valid", 32'(nv), 32'd0);
    check("rst_len_cleared_done", 32'(d), 32'(1 + LAT));
    load_env();
    reg_wr(0, 4);
    reg_wr(1, 2);
    reg_wr(2, 'h040);
    reg_wr(3, 'h0c0);
    play(-1, nv, nb, d);
    check("rst_reload_valid", 32'(nv), 32'd10);
    check("rst_reload_done", 32'(d), 32'(11 + LAT));

    // Randomized traffic, scored every cycle by the model.
    for (int it = 0; it < 2500; it++) begin
      if (it % 800 == 799) begin
        env_wr_en = 1'b0; reg_wr_en = 1'b0; meas_start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        load_env();
        continue;
      end
      env_wr_en   = ($urandom_range(0, 3) == 0);
      env_wr_addr = AW'($urandom);
      env_wr_data = DW'($urandom);
      reg_wr_en   = ($urandom_range(0, 5) == 0);
      reg_wr_addr = 2'($urandom);
      case (reg_wr_addr)
        2'd0:    reg_wr_data = ($urandom_range(0, 7) == 0) ? LW'($urandom_range(0, 127))
                                                           : LW'($urandom_range(0, 10));
        2'd1:    reg_wr_data = LW'($urandom_range(0, 8));
        default: reg_wr_data = LW'($urandom);
      endcase
      meas_start = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    env_wr_en = 1'b0; reg_wr_en = 1'b0; meas_start = 1'b0;
    repeat (300) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #400000;
    n_bad++;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
